// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the five-stage pipeline datapath and its hazard/memory controller.
// sram_start/sram_ready: start pulses once per access and ready may arrive on any later wait cycle; ready outside a wait is ignored.
interface pipeline_ctrl_if;
  logic        id_valid;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic        exe_wb_en;
  logic [3:0]  exe_dest;
  logic        exe_mem_r_en;
  logic        mem_wb_en;
  logic [3:0]  mem_dest;
  logic        fwd_en;
  logic        branch_taken;
  logic        mem_access;
  logic        sram_ready;
  logic        freeze_if;
  logic        flush_ifreg;
  logic        flush_idreg;
  logic        freeze_all;
  logic        sram_start;
  logic        mem_err;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, exe_wb_en, exe_dest, exe_mem_r_en,
           mem_wb_en, mem_dest, fwd_en, branch_taken, mem_access, sram_ready,
    input  freeze_if, flush_ifreg, flush_idreg, freeze_all, sram_start, mem_err, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, exe_wb_en, exe_dest, exe_mem_r_en,
           mem_wb_en, mem_dest, fwd_en, branch_taken, mem_access, sram_ready,
    output freeze_if, flush_ifreg, flush_idreg, freeze_all, sram_start, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: RAW/load-use hazard detection, branch flush, and a bounded SRAM wait FSM.
// state_dbg exposes the memory FSM state (0 idle, 1 waiting, 2 done).
module pipeline_ctrl #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus,
  output logic [1:0]       state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, MEM_WAIT = 2'd1, MEM_DONE = 2'd2} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [15:0] stall_q;
  logic        exe_match, mem_match, hazard;
  logic        freeze_all_c, start_c, freeze_if_c, flush_if_c, flush_id_c;

  always_comb begin
    exe_match = bus.exe_wb_en & ((bus.exe_dest == bus.id_src1) |
                                 (bus.id_two_src & (bus.exe_dest == bus.id_src2)));
    mem_match = bus.mem_wb_en & ((bus.mem_dest == bus.id_src1) |
                                 (bus.id_two_src & (bus.mem_dest == bus.id_src2)));
    // With forwarding only a load in EXE cannot be bypassed in time.
    if (bus.fwd_en) hazard = bus.id_valid & bus.exe_mem_r_en & exe_match;
    else            hazard = bus.id_valid & (exe_match | mem_match);
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    err_d        = err_q;
    freeze_all_c = 1'b0;
    start_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_access) begin
          state_d      = MEM_WAIT;
          wait_d       = 8'd0;
          freeze_all_c = 1'b1;
          start_c      = 1'b1;
        end
      end
      MEM_WAIT: begin
        freeze_all_c = 1'b1;
        // Ready wins over a timeout landing in the same cycle.
        if (bus.sram_ready) begin
          state_d = MEM_DONE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = MEM_DONE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      MEM_DONE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    freeze_if_c = 1'b0;
    flush_if_c  = 1'b0;
    flush_id_c  = 1'b0;
    if (freeze_all_c) begin
      freeze_if_c = 1'b1;
    end else if (bus.branch_taken) begin
      flush_if_c = 1'b1;
      flush_id_c = 1'b1;
    end else if (hazard) begin
      freeze_if_c = 1'b1;
      flush_id_c  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (freeze_if_c && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  // Reset forces every output low in the reset cycle itself.
  assign bus.freeze_if   = freeze_if_c & ~rst;
  assign bus.flush_ifreg = flush_if_c & ~rst;
  assign bus.flush_idreg = flush_id_c & ~rst;
  assign bus.freeze_all  = freeze_all_c & ~rst;
  assign bus.sram_start  = start_c & ~rst;
  assign bus.mem_err     = err_q & ~rst;
  assign bus.stall_cnt   = rst ? 16'd0 : stall_q;
  assign state_dbg       = rst ? 2'd0 : state_q;
endmodule
